mem_sequencer: RTL

- Memory-access sequencer between the multicycle controller/datapath and a unified instruction/data memory with variable latency.
- Turns the controller's per-state memory intents (memread, memwrite, irwrite, iord) into a req/ack handshake with memory.
- Captures returned data into the instruction register (IR) or memory data register (MDR).
- Holds the controller FSM with `stall` until the access completes.

---
 rtl/mem_seq_pkg.sv | 13 +
 rtl/mem_timeout_ctr.sv | 39 +++
 rtl/mem_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory-access sequencer.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
  localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/mem_timeout_ctr.sv
// REQ-phase watchdog: counts waiting cycles, flags the last allowed one.
// Only built with MEM_SEQUENCER_TIMEOUT_EN so the default build carries no orphan module.
`ifdef MEM_SEQUENCER_TIMEOUT_EN
module mem_timeout_ctr #(
  parameter int W     = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the cycle that would make the count reach LIMIT.
  assign tc_o = en_i && (cnt_q == W'(LIMIT - 1));

endmodule
`endif

// File: rtl/mem_sequencer.sv
// Turns multicycle-controller memory intents into a req/ack access and captures IR/MDR.
// Optional REQ timeout with bus_err is enabled by defining MEM_SEQUENCER_TIMEOUT_EN.
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memread,
  input  logic          memwrite,
  input  logic          irwrite,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] writedata,
  output logic          stall,
  output logic [DW-1:0] instr,
  output logic [DW-1:0] data,
  output logic          align_err,
  output logic          bus_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  state_t        state_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic          align_err_q;
  logic          bus_err_q;
  logic          dest_ir_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] instr_q;
  logic [DW-1:0] data_q;

  logic access;
  logic misaligned;
  logic to_hit;

  assign access     = memread | memwrite;
  assign misaligned = (adr[1:0] & WORD_ALIGN_MASK) != 2'b00;

`ifdef MEM_SEQUENCER_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  mem_timeout_ctr #(
    .W    (TO_W),
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk  (clk),
    .rst_n(reset),
    .clr_i(state_q != REQ),
    .en_i ((state_q == REQ) && !mem_ack),
    .tc_o (to_hit)
  );
`else
  assign to_hit = 1'b0;
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
      dest_ir_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      instr_q     <= '0;
      data_q      <= '0;
    end else begin
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access) begin
            mem_addr_q  <= {adr[AW-1:2], 2'b00};
            mem_wdata_q <= writedata;
            mem_we_q    <= memwrite;
            // A combined read+write request is serviced as a plain write.
            dest_ir_q   <= irwrite & ~memwrite;
            if (misaligned) begin
              align_err_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              mem_req_q <= 1'b1;
              state_q   <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) begin
              if (dest_ir_q) instr_q <= mem_rdata;
              else           data_q  <= mem_rdata;
            end
            state_q <= DONE;
          end else if (to_hit) begin
            mem_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            if (!mem_we_q) begin
              if (dest_ir_q) instr_q <= DW'(NOP_INSTR);
              else           data_q  <= DW'(NOP_INSTR);
            end
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // DONE is the single cycle in which the controller is allowed to advance.
  assign stall     = access & (state_q != DONE);
  assign instr     = instr_q;
  assign data      = data_q;
  assign align_err = align_err_q;
  assign bus_err   = bus_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
